// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table controller:
// FSM state encoding, counter threshold/init values and the saturating step.
package bht_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2
  } bht_state_e;

  localparam int unsigned BHT_N_DEF = 2;

  // Counters at or above the threshold predict taken.
  function automatic int unsigned taken_th(input int unsigned n);
    return 32'd1 << (n - 32'd1);
  endfunction

  function automatic int unsigned wnt_init(input int unsigned n);
    return taken_th(n) - 32'd1;
  endfunction

  localparam int unsigned BHT_TAKEN_TH = taken_th(BHT_N_DEF);
  localparam int unsigned BHT_WNT_INIT = wnt_init(BHT_N_DEF);

  function automatic int unsigned sat_next(input int unsigned cnt, input logic taken,
                                           input int unsigned n);
    int unsigned max_v;
    max_v = (32'd1 << n) - 32'd1;
    if (taken) return (cnt >= max_v) ? max_v : cnt + 32'd1;
    else       return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Counter storage for the BHT: register array with one combinational read
// port and one synchronous write port; contents are not reset.
module bht_table #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [N-1:0]     i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [N-1:0]     o_rdata
);

  logic [N-1:0] r_mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: init sweep, lookup/update arbitration with
// starvation guard, read-modify-write updates. Optional stats via BHT_STATS_EN.
module bht_ctrl
  import bht_pkg::*;
#(
  parameter int unsigned N          = BHT_N_DEF,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_ready,
  output logic             lk_pred_valid,
  output logic             lk_pred,
  input  logic             up_valid,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_taken,
  output logic             up_ready,
`ifdef BHT_STATS_EN
  input  logic             up_pred,
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_mispred,
`endif
  output logic             init_busy
);

  localparam int unsigned    SW     = $clog2(STARVE_MAX + 1);
  localparam logic [N-1:0]   L_TH   = N'(taken_th(N));
  localparam logic [N-1:0]   L_INIT = N'(wnt_init(N));
  localparam logic [IDX_W-1:0] L_LAST = '1;
  localparam logic [SW-1:0]  L_SMAX = SW'(STARVE_MAX);

  bht_state_e       r_state, w_next_state;
  logic [IDX_W-1:0] r_init_idx, r_wr_idx;
  logic [N-1:0]     r_wr_val;
  logic [SW-1:0]    r_starve;
  logic             r_pred_valid, r_pred;

  logic             w_lk_win, w_up_win, w_we, w_busy;
  logic [IDX_W-1:0] w_waddr, w_raddr;
  logic [N-1:0]     w_wdata, w_rdata, w_upd_val;

  bht_table #(.N(N), .IDX_W(IDX_W)) u_table (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_upd_val = N'(sat_next(32'(w_rdata), up_taken, N));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= INIT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      INIT:    if (r_init_idx == L_LAST) w_next_state = IDLE;
      IDLE:    if (w_up_win) w_next_state = WRITE;
      WRITE:   w_next_state = IDLE;
      default: w_next_state = INIT;
    endcase
  end

  // Update wins when alone or once it has lost STARVE_MAX contended cycles.
  always_comb begin
    w_lk_win = 1'b0;
    w_up_win = 1'b0;
    w_we     = 1'b0;
    w_busy   = 1'b0;
    w_raddr  = lk_idx;
    w_waddr  = r_wr_idx;
    w_wdata  = r_wr_val;
    case (r_state)
      INIT: begin
        w_busy  = 1'b1;
        w_we    = 1'b1;
        w_waddr = r_init_idx;
        w_wdata = L_INIT;
      end
      IDLE: begin
        w_up_win = up_valid && (!lk_valid || (r_starve == L_SMAX));
        w_lk_win = lk_valid && !w_up_win;
        if (w_up_win) w_raddr = up_idx;
      end
      WRITE:   w_we = 1'b1;
      default: w_busy = 1'b1;
    endcase
  end

  assign lk_ready      = w_lk_win;
  assign up_ready      = w_up_win;
  assign init_busy     = w_busy;
  assign lk_pred_valid = r_pred_valid;
  assign lk_pred       = r_pred;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_init_idx   <= '0;
      r_starve     <= '0;
      r_pred_valid <= 1'b0;
      r_pred       <= 1'b0;
    end else begin
      if (r_state == INIT) r_init_idx <= r_init_idx + 1'b1;
      if (r_state == IDLE) begin
        if (w_up_win || !up_valid) r_starve <= '0;
        else if (lk_valid)         r_starve <= r_starve + 1'b1;
      end
      r_pred_valid <= w_lk_win;
      if (w_lk_win) r_pred <= (w_rdata >= L_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (w_up_win) begin
      r_wr_idx <= up_idx;
      r_wr_val <= w_upd_val;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] r_stat_updates, r_stat_mispred;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_updates <= '0;
      r_stat_mispred <= '0;
    end else if (w_up_win) begin
      r_stat_updates <= r_stat_updates + 32'd1;
      if (up_pred != up_taken) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_updates = r_stat_updates;
  assign stat_mispred = r_stat_mispred;
`endif

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed testbench for bht_ctrl: init sweep, prediction, saturation,
// starvation guard, reset during WRITE and (with BHT_STATS_EN) statistics.
module tb_bht_ctrl;

  logic       clk;
  logic       reset;
  logic       lk_valid;
  logic [3:0] lk_idx;
  logic       lk_ready;
  logic       lk_pred_valid;
  logic       lk_pred;
  logic       up_valid;
  logic [3:0] up_idx;
  logic       up_taken;
  logic       up_ready;
  logic       init_busy;
`ifdef BHT_STATS_EN
  logic        up_pred;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispred;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  bht_ctrl #(.N(2), .IDX_W(4), .STARVE_MAX(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .lk_valid      (lk_valid),
    .lk_idx        (lk_idx),
    .lk_ready      (lk_ready),
    .lk_pred_valid (lk_pred_valid),
    .lk_pred       (lk_pred),
    .up_valid      (up_valid),
    .up_idx        (up_idx),
    .up_taken      (up_taken),
    .up_ready      (up_ready),
`ifdef BHT_STATS_EN
    .up_pred       (up_pred),
    .stat_updates  (stat_updates),
    .stat_mispred  (stat_mispred),
`endif
    .init_busy     (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts edges until lk_ready rises (lk_valid must be held by the caller).
  task automatic wait_ready(input string tag);
    int cnt;
    cnt = 0;
    #1;
    while (lk_ready !== 1'b1 && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk(tag, cnt, 16);
    chk({tag, "_busy"}, init_busy, 1'b0);
  endtask

  task automatic do_lookup(input logic [3:0] idx, input logic exp_pred, input string tag);
    lk_valid = 1'b1;
    lk_idx   = idx;
    #1;
    chk({tag, "_rdy"}, lk_ready, 1'b1);
    @(posedge clk); #1;
    lk_valid = 1'b0;
    chk({tag, "_pv"}, lk_pred_valid, 1'b1);
    chk({tag, "_pred"}, lk_pred, exp_pred);
  endtask

  task automatic do_update(input logic [3:0] idx, input logic taken, input logic pred,
                           input string tag);
    up_valid = 1'b1;
    up_idx   = idx;
    up_taken = taken;
`ifdef BHT_STATS_EN
    up_pred  = pred;
`else
    if (pred === 1'bx) $display("note: unknown pred bit");
`endif
    #1;
    chk({tag, "_urdy"}, up_ready, 1'b1);
    @(posedge clk); #1;
    up_valid = 1'b0;
    #1;
    chk({tag, "_wr_urdy"}, up_ready, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset    = 1'b0;
    lk_valid = 1'b0;
    lk_idx   = '0;
    up_valid = 1'b0;
    up_idx   = '0;
    up_taken = 1'b0;
`ifdef BHT_STATS_EN
    up_pred  = 1'b0;
`endif
    #3;
    chk("rst_lk_ready", lk_ready, 1'b0);
    chk("rst_up_ready", up_ready, 1'b0);
    chk("rst_pred_valid", lk_pred_valid, 1'b0);
    chk("rst_pred", lk_pred, 1'b0);
    chk("rst_init_busy", init_busy, 1'b1);
`ifdef BHT_STATS_EN
    chk("rst_stat_upd", stat_updates, 0);
    chk("rst_stat_mis", stat_mispred, 0);
`endif

    // Sweep: held lookup on idx 3 waits 16 cycles, then predicts not-taken.
    @(posedge clk); #1;
    reset    = 1'b1;
    lk_valid = 1'b1;
    lk_idx   = 4'd3;
    wait_ready("init_wait");
    @(posedge clk); #1;
    lk_valid = 1'b0;
    chk("first_pv", lk_pred_valid, 1'b1);
    chk("first_pred", lk_pred, 1'b0);

    // idx 5: 1 -> 2 -> 3, saturate at 3, then down to 2 and 1.
    do_update(4'd5, 1'b1, 1'b0, "u5a");
    do_update(4'd5, 1'b1, 1'b0, "u5b");
    do_lookup(4'd5, 1'b1, "lk5_2");
    do_update(4'd5, 1'b1, 1'b0, "u5c");
    do_update(4'd5, 1'b1, 1'b0, "u5d");
    do_update(4'd5, 1'b1, 1'b0, "u5e");
    do_update(4'd5, 1'b0, 1'b0, "u5f");
    do_lookup(4'd5, 1'b1, "lk5_sat");
    do_update(4'd5, 1'b0, 1'b0, "u5g");
    do_lookup(4'd5, 1'b0, "lk5_1");

    // idx 0: 1 -> 0 -> 0 (floor saturation).
    do_update(4'd0, 1'b0, 1'b0, "u0a");
    do_update(4'd0, 1'b0, 1'b0, "u0b");
    do_lookup(4'd0, 1'b0, "lk0");
    do_update(4'd0, 1'b1, 1'b0, "u0c");
    do_lookup(4'd0, 1'b0, "lk0_floor");

    // Starvation: update wins on the 5th contended cycle.
    lk_valid = 1'b1;
    lk_idx   = 4'd7;
    up_valid = 1'b1;
    up_idx   = 4'd7;
    up_taken = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("starve_lk_rdy_%0d", c), lk_ready, (c < 5));
      chk($sformatf("starve_up_rdy_%0d", c), up_ready, (c == 5));
      @(posedge clk); #1;
    end
    up_valid = 1'b0;
    #1;
    chk("starve_wr_lk_rdy", lk_ready, 1'b0);
    chk("starve_wr_pv", lk_pred_valid, 1'b0);
    @(posedge clk); #1;
    chk("starve_after_lk_rdy", lk_ready, 1'b1);
    chk("starve_after_pv", lk_pred_valid, 1'b0);
    @(posedge clk); #1;
    lk_valid = 1'b0;
    chk("starve_resume_pv", lk_pred_valid, 1'b1);
    chk("starve_resume_pred", lk_pred, 1'b1);

    // Reset asserted during the WRITE cycle of an update.
    up_valid = 1'b1;
    up_idx   = 4'd9;
    up_taken = 1'b1;
    #1;
    @(posedge clk); #1;
    up_valid = 1'b0;
    lk_valid = 1'b1;
    lk_idx   = 4'd9;
    reset    = 1'b0;
    #1;
    chk("rst2_lk_ready", lk_ready, 1'b0);
    chk("rst2_up_ready", up_ready, 1'b0);
    chk("rst2_init_busy", init_busy, 1'b1);
    chk("rst2_pred", lk_pred, 1'b0);
    chk("rst2_pred_valid", lk_pred_valid, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset  = 1'b1;
    lk_idx = 4'd0;
    wait_ready("init2_wait");

    // Back-to-back lookups of every entry: all weakly not-taken.
    for (int i = 0; i < 16; i++) begin
      lk_idx = 4'(i);
      @(posedge clk); #1;
      chk($sformatf("sweep_pv_%0d", i), lk_pred_valid, 1'b1);
      chk($sformatf("sweep_pred_%0d", i), lk_pred, 1'b0);
    end
    lk_valid = 1'b0;

    // One taken update from 1 crosses the threshold; two mispredicted.
    do_update(4'd5,  1'b1, 1'b1, "s5");
    do_update(4'd7,  1'b1, 1'b1, "s7");
    do_update(4'd9,  1'b1, 1'b0, "s9");
    do_update(4'd10, 1'b0, 1'b0, "s10");
    do_update(4'd11, 1'b0, 1'b1, "s11");
    do_update(4'd12, 1'b1, 1'b1, "s12");
    do_lookup(4'd5,  1'b1, "lk_s5");
    do_lookup(4'd7,  1'b1, "lk_s7");
    do_lookup(4'd9,  1'b1, "lk_s9");
    do_lookup(4'd10, 1'b0, "lk_s10");
    do_lookup(4'd12, 1'b1, "lk_s12");
`ifdef BHT_STATS_EN
    chk("stat_updates", stat_updates, 6);
    chk("stat_mispred", stat_mispred, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/bht_ctrl.md
# bht_ctrl

Branch history table controller: owns a table of 2^IDX_W N-bit saturating counters and sequences all accesses to it. Serves a lookup port (prediction) and an update port (resolved branch outcome) that share one table access per cycle, with a starvation guard for updates. After reset, sweeps the table to a known state. Sits between fetch (lookups) and execute/commit (updates) in the predictor.

## Interface
- N, 2: counter width in bits; taken threshold is 2^(N-1).
- IDX_W, 4: table index width; 2^IDX_W entries.
- STARVE_MAX, 4: consecutive lost arbitrations after which a pending update wins.

- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- lk_valid  input  1  lookup request.
- lk_idx  input  IDX_W  lookup index.
- lk_ready  output  1  lookup accepted this cycle when lk_valid && lk_ready.
- lk_pred_valid  output  1  registered prediction valid, one cycle after accept.
- lk_pred  output  1  prediction: 1 = taken.
- up_valid  input  1  update request.
- up_idx  input  IDX_W  update index.
- up_taken  input  1  resolved outcome.
- up_ready  output  1  update accepted when up_valid && up_ready.
- init_busy  output  1  table sweep in progress.
- Only with BHT_STATS_EN: up_pred input 1 (prediction originally made); stat_updates output 32; stat_mispred output 32.

## Operation
- States: INIT, IDLE, WRITE.
- INIT: entered on reset. Writes entry k = 0..2^IDX_W-1, one per cycle, value 2^(N-1)-1 (weakly not-taken). lk_ready = up_ready = 0, init_busy = 1. After the last entry, go to IDLE, init_busy = 0.
- IDLE: one table access per cycle. Arbitration:
  - only lk_valid: lookup wins.
  - only up_valid: update wins.
  - both: lookup wins, starve counter +1; if starve counter == STARVE_MAX, update wins instead.
  - starve counter clears when an update is accepted or up_valid is low.
- lk_ready and up_ready are driven combinationally from the arbitration result; at most one is 1 per cycle.
- Lookup: read entry lk_idx; next cycle lk_pred_valid = 1 and lk_pred = (counter >= 2^(N-1)). Otherwise lk_pred_valid = 0 and lk_pred holds its last value.
- Update accept: read entry up_idx, register the index and the next value, go to WRITE.
  - Next value when taken: counter + 1, saturates at 2^N-1.
  - Next value when not taken: counter - 1, saturates at 0.
- WRITE: write the registered value; lk_ready = up_ready = 0; return to IDLE.
- A lookup accepted in the cycle after WRITE sees the written value; no forwarding needed.
- Reset asserted at any time: immediately enter INIT. An in-flight WRITE is abandoned; the sweep overwrites the entry.

## Timing
- Reset values: lk_ready 0, up_ready 0, lk_pred_valid 0, lk_pred 0, init_busy 1, starve counter 0, stats 0.
- First ready asserts 2^IDX_W cycles after reset deasserts (16 at defaults).
- Lookup latency: 1 cycle. Back-to-back lookups sustain 1 per cycle.
- Update occupancy: 2 cycles (accept + WRITE). Peak update throughput is 1 per 2 cycles.
- Worst-case update wait under continuous lookups: STARVE_MAX cycles.

## Configuration
- BHT_STATS_EN defined:
  - up_pred, stat_updates and stat_mispred ports exist.
  - stat_updates +1 per accepted update.
  - stat_mispred +1 per accepted update with up_pred != up_taken.
  - Both counters wrap at 2^32 and clear on reset.
- BHT_STATS_EN undefined: those ports and registers are absent. Prediction and update behaviour is identical.

## Structure
- Package bht_pkg holds:
  - state enum (INIT, IDLE, WRITE).
  - localparams for the taken threshold and the weakly-not-taken init value.
  - a saturating next-value function of (counter, taken).
- Sub-module bht_table: 2^IDX_W x N register array, one combinational read port and one write port, no reset.
- bht_ctrl contains the FSM, arbiter, starve counter, output registers and optional stats.

## Test plan
- Reset, then hold lk_valid on idx 3 -> lk_ready low for 16 cycles; first prediction is lk_pred = 0 (entry = 1).
- Two taken updates on idx 5, then a lookup on idx 5 -> lk_pred = 1; three more taken updates keep the entry at 3 (saturation); one not-taken update -> 2, lk_pred still 1.
- Not-taken updates on idx 0 from 1 -> entry stays at 0; lk_pred = 0.
- lk_valid held high every cycle with up_valid pending -> update accepted on the 5th contended cycle (STARVE_MAX = 4); lookups resume after WRITE.
- Reset asserted during WRITE -> outputs take reset values immediately; after the sweep every entry reads 1.
- With BHT_STATS_EN: 6 updates, of which 2 have up_pred != up_taken -> stat_updates = 6, stat_mispred = 2.
